// File: rtl/memory_access_if.sv
// Data-memory req/ack bus between the memory-access stage (master) and data memory (slave).
// Byte enables are numbered MSB-first: dmem_byte_en[0] covers the most significant byte.
interface memory_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [0:3]  dmem_byte_en;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: word/byte loads and stores over a req/ack data-memory bus,
// stalling upstream while an access is outstanding and aborting after TIMEOUT_CYCLES.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned word accesses and
// report them on misalign_out (port exists only in that build).
// Byte lanes are big-endian: address offset 0 is bits [31:24].
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CONTROL_BITS   = 8,
  parameter int unsigned MEM_WE         = 0,
  parameter int unsigned MEM_READ       = 1,
  parameter int unsigned REG_WE         = 2,
  parameter int unsigned LINK           = 3,
  parameter int unsigned ACCESS_SIZE_B1 = 4,
  parameter int unsigned ACCESS_SIZE_B2 = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             insn_in,
  input  logic [31:0]             result_data_in,
  input  logic [31:0]             rt_data_in,
  input  logic [4:0]              rd_in,
  input  logic [CONTROL_BITS-1:0] control_in,
  output logic                    stall_out,
  memory_access_if.master         dmem_bus,
  output logic [31:0]             wb_data_out,
  output logic [4:0]              rd_out,
  output logic                    reg_we_out,
  output logic [31:0]             insn_out,
  output logic [CONTROL_BITS-1:0] control_out,
  output logic                    mem_error_out
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                    misalign_out
`endif
);

  localparam int unsigned CntW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0]  OpLbu    = 6'b100100;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e            state_q;
  logic [CntW-1:0]   wait_cnt_q;

  // Captured operation, needed to form the write-back once the ack arrives.
  logic                    load_q;
  logic                    byte_q;
  logic                    lbu_q;
  logic [1:0]              off_q;
  logic [4:0]              rd_q;
  logic [31:0]             insn_q;
  logic [CONTROL_BITS-1:0] ctrl_q;

  logic        mem_op;
  logic        is_byte;
  logic        misaligned;
  logic [1:0]  offset;
  logic [0:3]  byte_en_d;
  logic [31:0] wdata_d;
  logic [7:0]  lane;
  logic [31:0] load_data;

  assign stall_out = (state_q == StWait);

  // Decode the incoming op into the bus values it would issue.
  always_comb begin
    mem_op  = (insn_in != 32'd0) && (control_in[MEM_READ] || control_in[MEM_WE]);
    // Only size 00 is a byte access; 01 and 10 fall back to word.
    is_byte = !control_in[ACCESS_SIZE_B1] && !control_in[ACCESS_SIZE_B2];
    offset  = result_data_in[1:0];
    if (is_byte) begin
      byte_en_d = 4'b1000 >> offset;
      wdata_d   = {4{rt_data_in[7:0]}};
    end else begin
      byte_en_d = 4'b1111;
      wdata_d   = rt_data_in;
    end
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = !is_byte && (offset != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  // Extract and extend the addressed byte lane for byte loads.
  always_comb begin
    lane = 8'h00;
    unique case (off_q)
      2'd0: lane = dmem_bus.dmem_rdata[31:24];
      2'd1: lane = dmem_bus.dmem_rdata[23:16];
      2'd2: lane = dmem_bus.dmem_rdata[15:8];
      2'd3: lane = dmem_bus.dmem_rdata[7:0];
    endcase
    if (!byte_q) begin
      load_data = dmem_bus.dmem_rdata;
    end else if (lbu_q) begin
      load_data = {24'h000000, lane};
    end else begin
      load_data = {{24{lane[7]}}, lane};
    end
  end

  // Stage FSM: all outputs registered; bubbles while waiting or aborting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q               <= StIdle;
      wait_cnt_q            <= '0;
      load_q                <= 1'b0;
      byte_q                <= 1'b0;
      lbu_q                 <= 1'b0;
      off_q                 <= 2'b00;
      rd_q                  <= 5'd0;
      insn_q                <= 32'd0;
      ctrl_q                <= '0;
      dmem_bus.dmem_req     <= 1'b0;
      dmem_bus.dmem_we      <= 1'b0;
      dmem_bus.dmem_addr    <= 32'd0;
      dmem_bus.dmem_wdata   <= 32'd0;
      dmem_bus.dmem_byte_en <= 4'b0000;
      wb_data_out           <= 32'd0;
      rd_out                <= 5'd0;
      reg_we_out            <= 1'b0;
      insn_out              <= 32'd0;
      control_out           <= '0;
      mem_error_out         <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_out          <= 1'b0;
`endif
    end else begin
      mem_error_out <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_out  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (insn_in == 32'd0 || (mem_op && misaligned)) begin
            wb_data_out <= 32'd0;
            rd_out      <= 5'd0;
            reg_we_out  <= 1'b0;
            insn_out    <= 32'd0;
            control_out <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_out <= mem_op && misaligned;
`endif
          end else if (mem_op) begin
            load_q                <= !control_in[MEM_WE];
            byte_q                <= is_byte;
            lbu_q                 <= (insn_in[31:26] == OpLbu);
            off_q                 <= offset;
            rd_q                  <= rd_in;
            insn_q                <= insn_in;
            ctrl_q                <= control_in;
            dmem_bus.dmem_req     <= 1'b1;
            dmem_bus.dmem_we      <= control_in[MEM_WE];
            dmem_bus.dmem_addr    <= {result_data_in[31:2], 2'b00};
            dmem_bus.dmem_wdata   <= wdata_d;
            dmem_bus.dmem_byte_en <= byte_en_d;
            wait_cnt_q            <= '0;
            state_q               <= StWait;
            wb_data_out           <= 32'd0;
            rd_out                <= 5'd0;
            reg_we_out            <= 1'b0;
            insn_out              <= 32'd0;
            control_out           <= '0;
          end else begin
            wb_data_out <= control_in[LINK] ? rt_data_in : result_data_in;
            rd_out      <= rd_in;
            reg_we_out  <= control_in[REG_WE];
            insn_out    <= insn_in;
            control_out <= control_in;
          end
        end
        StWait: begin
          if (dmem_bus.dmem_ack) begin
            dmem_bus.dmem_req <= 1'b0;
            state_q           <= StIdle;
            wb_data_out       <= load_q ? load_data : 32'd0;
            rd_out            <= rd_q;
            reg_we_out        <= load_q;
            insn_out          <= insn_q;
            control_out       <= ctrl_q;
          end else if (wait_cnt_q == CntLast) begin
            dmem_bus.dmem_req <= 1'b0;
            state_q           <= StIdle;
            mem_error_out     <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through ops, word/byte loads and stores,
// timeout abort, reset during an access and the alignment option.
module tb_memory_access;

  localparam logic [7:0] CMemWe   = 8'h01;
  localparam logic [7:0] CMemRead = 8'h02;
  localparam logic [7:0] CRegWe   = 8'h04;
  localparam logic [7:0] CLink    = 8'h08;
  localparam logic [7:0] CWord    = 8'h30;

  localparam logic [31:0] InsnAddu = 32'h00851021;
  localparam logic [31:0] InsnJal  = 32'h0C000010;
  localparam logic [31:0] InsnLw   = 32'h8C020000;
  localparam logic [31:0] InsnLb   = 32'h80020000;
  localparam logic [31:0] InsnLbu  = 32'h90020000;
  localparam logic [31:0] InsnSb   = 32'hA0020000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_in;
  logic [31:0] result_data_in;
  logic [31:0] rt_data_in;
  logic [4:0]  rd_in;
  logic [7:0]  control_in;
  logic        stall_out;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        reg_we_out;
  logic [31:0] insn_out;
  logic [7:0]  control_out;
  logic        mem_error_out;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  memory_access_if dmem_bus();

  memory_access dut (
    .clock          (clock),
    .reset          (reset),
    .insn_in        (insn_in),
    .result_data_in (result_data_in),
    .rt_data_in     (rt_data_in),
    .rd_in          (rd_in),
    .control_in     (control_in),
    .stall_out      (stall_out),
    .dmem_bus       (dmem_bus),
    .wb_data_out    (wb_data_out),
    .rd_out         (rd_out),
    .reg_we_out     (reg_we_out),
    .insn_out       (insn_out),
    .control_out    (control_out),
    .mem_error_out  (mem_error_out)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_out   (misalign_out)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] res, input logic [31:0] rt,
                       input logic [4:0] rd, input logic [7:0] ctrl);
    insn_in        = insn;
    result_data_in = res;
    rt_data_in     = rt;
    rd_in          = rd;
    control_in     = ctrl;
  endtask

  // Called right after the accepting edge: returns ack on the edge 'delay' cycles later
  // and counts cycles in which stall_out was high.
  task automatic serve(input int delay, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    drive(32'd0, 32'd0, 32'd0, 5'd0, 8'h00);
    for (int i = 0; i < delay; i++) begin
      if (stall_out) stalls++;
      if (i == delay - 1) begin
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = rdata;
      end
      tick();
    end
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
  endtask

  initial begin
    int stalls;
    reset = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 5'd0, 8'h00);
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    tick();
    tick();
    check("rst_req", 32'(dmem_bus.dmem_req), 32'h0);
    check("rst_stall", 32'(stall_out), 32'h0);
    check("rst_wb", wb_data_out, 32'h0);
    check("rst_regwe", 32'(reg_we_out), 32'h0);
    check("rst_be", 32'(dmem_bus.dmem_byte_en), 32'h0);
    check("rst_err", 32'(mem_error_out), 32'h0);
    reset = 1'b0;

    // ADDU passes straight through in one edge.
    drive(InsnAddu, 32'h7, 32'h1234, 5'd5, CRegWe);
    #1;
    check("addu_stall", 32'(stall_out), 32'h0);
    tick();
    check("addu_wb", wb_data_out, 32'h7);
    check("addu_rd", 32'(rd_out), 32'h5);
    check("addu_we", 32'(reg_we_out), 32'h1);
    check("addu_stall2", 32'(stall_out), 32'h0);

    // JAL writes the link value from rt.
    drive(InsnJal, 32'h999, 32'h108, 5'd31, CRegWe | CLink);
    tick();
    check("jal_wb", wb_data_out, 32'h108);

    // NOP becomes a bubble.
    drive(32'd0, 32'h55, 32'h66, 5'd7, CRegWe);
    tick();
    check("nop_insn", insn_out, 32'h0);
    check("nop_we", 32'(reg_we_out), 32'h0);

    // LW 0x100, ack sampled three edges after the request.
    drive(InsnLw, 32'h100, 32'h0, 5'd9, CMemRead | CRegWe | CWord);
    tick();
    check("lw_req", 32'(dmem_bus.dmem_req), 32'h1);
    check("lw_addr", dmem_bus.dmem_addr, 32'h100);
    check("lw_be", 32'(dmem_bus.dmem_byte_en), 32'hF);
    check("lw_bubble", 32'(reg_we_out), 32'h0);
    serve(3, 32'hDEADBEEF, stalls);
    check("lw_stalls", 32'(stalls), 32'd3);
    check("lw_wb", wb_data_out, 32'hDEADBEEF);
    check("lw_we", 32'(reg_we_out), 32'h1);
    check("lw_rd", 32'(rd_out), 32'd9);
    check("lw_req_drop", 32'(dmem_bus.dmem_req), 32'h0);

    // LB / LBU at 0x103 with zero-wait memory.
    drive(InsnLb, 32'h103, 32'h0, 5'd4, CMemRead | CRegWe);
    tick();
    check("lb_be", 32'(dmem_bus.dmem_byte_en), 32'h1);
    check("lb_addr", dmem_bus.dmem_addr, 32'h100);
    serve(1, 32'h11223380, stalls);
    check("lb_wb", wb_data_out, 32'hFFFFFF80);
    drive(InsnLbu, 32'h103, 32'h0, 5'd4, CMemRead | CRegWe);
    tick();
    check("lbu_be", 32'(dmem_bus.dmem_byte_en), 32'h1);
    serve(1, 32'h11223380, stalls);
    check("lbu_wb", wb_data_out, 32'h00000080);

    // LB at lane 0 picks the most significant byte.
    drive(InsnLb, 32'h100, 32'h0, 5'd4, CMemRead | CRegWe);
    tick();
    check("lb0_be", 32'(dmem_bus.dmem_byte_en), 32'h8);
    serve(2, 32'h7F00_00FF, stalls);
    check("lb0_wb", wb_data_out, 32'h0000007F);

    // SB 0xA5 at 0x201.
    drive(InsnSb, 32'h201, 32'h000000A5, 5'd0, CMemWe);
    tick();
    check("sb_addr", dmem_bus.dmem_addr, 32'h200);
    check("sb_be", 32'(dmem_bus.dmem_byte_en), 32'h4);
    check("sb_wdata", dmem_bus.dmem_wdata, 32'hA5A5A5A5);
    check("sb_we", 32'(dmem_bus.dmem_we), 32'h1);
    serve(2, 32'h0, stalls);
    check("sb_regwe", 32'(reg_we_out), 32'h0);

    // LW with no ack: abort after 16 WAIT cycles.
    drive(InsnLw, 32'h300, 32'h0, 5'd8, CMemRead | CRegWe | CWord);
    tick();
    drive(32'd0, 32'd0, 32'd0, 5'd0, 8'h00);
    stalls = 0;
    while (stall_out && stalls < 40) begin
      stalls++;
      tick();
    end
    check("to_cycles", 32'(stalls), 32'd16);
    check("to_err", 32'(mem_error_out), 32'h1);
    check("to_req", 32'(dmem_bus.dmem_req), 32'h0);
    check("to_regwe", 32'(reg_we_out), 32'h0);
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'hBAD0BAD0;
    tick();
    dmem_bus.dmem_ack   = 1'b0;
    check("to_err_pulse", 32'(mem_error_out), 32'h0);
    check("late_ack_stall", 32'(stall_out), 32'h0);
    check("late_ack_we", 32'(reg_we_out), 32'h0);
    drive(InsnAddu, 32'h55, 32'h0, 5'd3, CRegWe);
    tick();
    check("post_to_wb", wb_data_out, 32'h55);
    check("post_to_we", 32'(reg_we_out), 32'h1);

    // Reset in the middle of a WAIT.
    drive(InsnLw, 32'h400, 32'h0, 5'd2, CMemRead | CRegWe | CWord);
    tick();
    check("rw_req", 32'(dmem_bus.dmem_req), 32'h1);
    reset = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 5'd0, 8'h00);
    tick();
    reset = 1'b0;
    check("rw_req0", 32'(dmem_bus.dmem_req), 32'h0);
    check("rw_stall", 32'(stall_out), 32'h0);
    check("rw_wb", wb_data_out, 32'h0);
    check("rw_addr", dmem_bus.dmem_addr, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    drive(InsnLw, 32'h102, 32'h0, 5'd2, CMemRead | CRegWe | CWord);
    tick();
    check("mis_pulse", 32'(misalign_out), 32'h1);
    check("mis_req", 32'(dmem_bus.dmem_req), 32'h0);
    check("mis_stall", 32'(stall_out), 32'h0);
    check("mis_we", 32'(reg_we_out), 32'h0);
    drive(32'd0, 32'd0, 32'd0, 5'd0, 8'h00);
    tick();
    check("mis_pulse_end", 32'(misalign_out), 32'h0);
`else
    drive(InsnLw, 32'h102, 32'h0, 5'd2, CMemRead | CRegWe | CWord);
    tick();
    check("mis_addr", dmem_bus.dmem_addr, 32'h100);
    check("mis_req", 32'(dmem_bus.dmem_req), 32'h1);
    serve(1, 32'hCAFEF00D, stalls);
    check("mis_wb", wb_data_out, 32'hCAFEF00D);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline stage directly downstream of the execute stage. It consumes the ALU result, store data, destination register, instruction and control word, and performs loads and stores (word and byte) through a req/ack data-memory port. While an access is outstanding it stalls upstream. It then presents registered write-back data to the write-back stage.

## Interface
- `TIMEOUT_CYCLES`, default 16: cycles in WAIT without `dmem_ack` before the access is aborted.
- `clock` in, 1: single clock, rising edge.
- `reset` in, 1: synchronous, active-high.
- `insn_in` in, 32: instruction from execute; 0 = NOP.
- `result_data_in` in, 32: ALU result or effective address.
- `rt_data_in` in, 32: store data, or PC+8 for JAL.
- `rd_in` in, 5: destination register.
- `control_in` in, `CONTROL_BITS`: uses `MEM_WE`, `MEM_READ`, `REG_WE`, `LINK`, `ACCESS_SIZE_b1`/`b2`.
- `stall_out` out, 1: execute/upstream must hold while high.
- `dmem_req` out, 1; `dmem_we` out, 1; `dmem_addr` out, 32 (word-aligned); `dmem_wdata` out, 32; `dmem_byte_en` out, 4 (bit 0 = bits 0:7, MSB byte).
- `dmem_ack` in, 1; `dmem_rdata` in, 32.
- `wb_data_out` out, 32; `rd_out` out, 5; `reg_we_out` out, 1; `insn_out` out, 32; `control_out` out, `CONTROL_BITS`.
- `mem_error_out` out, 1: one-cycle pulse on timeout abort.
- `misalign_out` out, 1: only with `MEM_ALIGN_CHECK_EN`; otherwise not present.

## Operation
- FSM states are IDLE and WAIT.
- **Memory op** = `insn_in`≠0 and (`MEM_READ` or `MEM_WE`).
- **IDLE, non-memory op:** at the edge, register outputs.
  - `wb_data_out` = `rt_data_in` if `LINK`, else `result_data_in`.
  - `reg_we_out` = `REG_WE`.
  - `rd_out`, `insn_out` and `control_out` pass through.
- **IDLE, NOP:** register a bubble: `insn_out`=0, `reg_we_out`=0, `control_out`=0, `wb_data_out`=0.
- **IDLE, memory op:** capture the op, assert `dmem_req`, drive the address, write enable, byte enables and write data, then go to WAIT. Outputs show a bubble while in WAIT.
- **Access size:** `ACCESS_SIZE`=11 is word; 00 is byte; 01/10 are treated as word.
- **Address:** `dmem_addr` = {addr[0:29],00}.
- **Word access:** `dmem_byte_en`=1111 and `dmem_wdata`=rt.
- **Byte access:** `dmem_byte_en` is one-hot at bit addr[30:31]. For stores, `dmem_wdata` replicates rt[24:31] into all four lanes.
- **Loads:** the selected lane is placed in bits [24:31].
  - LB (opcode 100000) sign-extends.
  - LBU (100100) zero-extends.
  - Word loads return `dmem_rdata` unchanged.
- **WAIT:**
  - `dmem_req` and all `dmem_*` outputs are held stable until `dmem_ack` is sampled high.
  - On ack: drop `dmem_req`, register the write-back (loads: data, `reg_we_out`=1; stores: `reg_we_out`=0) and return to IDLE.
- **Timeout:** a counter starts at 0 on entering WAIT. If it reaches `TIMEOUT_CYCLES` with no ack:
  - drop `dmem_req` and return to IDLE;
  - pulse `mem_error_out`;
  - register a bubble (no register write).
- **Boundary cases:**
  - `dmem_ack` in IDLE is ignored.
  - A late ack after a timeout is ignored.
  - Reset during WAIT aborts the access at that edge with no write-back.

## Timing
- **Reset values:** state IDLE; `dmem_req`, `dmem_we`, `dmem_byte_en`, `dmem_addr`, `dmem_wdata`, `wb_data_out`, `rd_out`, `reg_we_out`, `insn_out`, `control_out`, `stall_out`, `mem_error_out` and `misalign_out` are all 0.
- **Non-memory ops:** latency is 1 edge.
- **Memory ops:**
  - Accepted at edge E0, so `dmem_req` is high from E0.
  - If ack is sampled at E1 (zero-wait memory), write-back is valid after E1. Minimum latency is 2 edges.
  - Each extra wait cycle adds 1.
- **`stall_out`:** combinational, equal to (state==WAIT). Upstream inputs are ignored while it is high. A new op is accepted on the edge that exits WAIT only in the following cycle, when inputs are sampled again in IDLE.
- **Timeout:** `mem_error_out` is high for exactly the one cycle after the aborting edge.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:**
  - A word access with addr[30:31]≠00 is not issued. No stall occurs and `dmem_req` stays 0.
  - `misalign_out` pulses for 1 cycle and a bubble is registered.
- **`MEM_ALIGN_CHECK_EN` undefined:** the low address bits are dropped and the access proceeds at the aligned word. No `misalign_out` port exists.

## Test plan
- ADDU, result 0x0000_0007, rd=5, `REG_WE` → after 1 edge `wb_data_out`=7, `rd_out`=5, `reg_we_out`=1, `stall_out` never high.
- LW at 0x100, ack 3 cycles after req, rdata 0xDEAD_BEEF → `stall_out` high 3 cycles, `dmem_byte_en`=1111, then `wb_data_out`=0xDEAD_BEEF with `reg_we_out`=1.
- LB at 0x103 and LBU at 0x103, rdata 0x1122_3380 → LB gives 0xFFFF_FF80 and LBU gives 0x0000_0080; `dmem_byte_en`=0001 for both.
- SB rt=0x0000_00A5 at 0x201 → `dmem_addr`=0x200, `dmem_byte_en`=0100, `dmem_wdata`=0xA5A5_A5A5, `dmem_we`=1, no register write.
- LW with ack never returned, `TIMEOUT_CYCLES`=16 → `dmem_req` drops after 16 WAIT cycles, `mem_error_out` pulses once, a late ack is ignored, and the next ADDU completes normally.
- Reset asserted during WAIT → next cycle `dmem_req`=0, `stall_out`=0, all outputs 0. With `MEM_ALIGN_CHECK_EN`, LW at 0x102 → `misalign_out` pulses and `dmem_req` stays 0.
